// File: rtl/exe_wb_stage.sv
// Execute stage with EXE/WB pipeline register. Single-cycle ALU ops complete in
// one cycle; MUL runs an LSB-first shift-add sequencer and stalls upstream.
module exe_wb_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] imm_in,
    input  logic [2:0]       opcode_in,
    input  logic             alusrc_in,
    input  logic [ASIZE-1:0] waddr_in,
    output logic [DSIZE-1:0] result_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             stall
);

    localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0] acc_q, acc_d;
    logic [DSIZE-1:0] mcand_q, mcand_d;
    logic [DSIZE-1:0] mplr_q, mplr_d;
    logic [DSIZE-1:0] result_q, result_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic             wen_q, wen_d;

    logic [DSIZE-1:0] opb;
    logic [DSIZE-1:0] alu_res;
    logic [DSIZE-1:0] addend;
    logic             wen_rule;

    // Partial product for the current multiplier bit.
    generate
        for (genvar gi = 0; gi < DSIZE; gi++) begin : g_addend
            assign addend[gi] = mcand_q[gi] & mplr_q[0];
        end
    endgenerate

    always_comb begin
        opb      = alusrc_in ? imm_in : rdata2_in;
        wen_rule = (opcode_in != OP_NOP) && (waddr_in != '0);
        alu_res  = '0;
        case (opcode_in)
            OP_ADD:  alu_res = rdata1_in + opb;
            OP_SUB:  alu_res = rdata1_in - opb;
            OP_AND:  alu_res = rdata1_in & opb;
            OP_OR:   alu_res = rdata1_in | opb;
            OP_XOR:  alu_res = rdata1_in ^ opb;
            OP_SLT:  alu_res = {{(DSIZE-1){1'b0}}, ($signed(rdata1_in) < $signed(opb))};
            default: alu_res = '0;
        endcase
    end

    // Reset also drops stall so upstream is released while the stage is cleared.
    assign stall = !rst && (((state_q == IDLE) && (opcode_in == OP_MUL)) || (state_q == BUSY));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        wen_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (opcode_in == OP_MUL) begin
                    mcand_d = rdata1_in;
                    mplr_d  = opb;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    result_d = alu_res;
                    waddr_d  = waddr_in;
                    wen_d    = wen_rule;
                end
            end
            BUSY: begin
                acc_d   = acc_q + addend;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DSIZE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // ID/EXE is still held here, so waddr_in is the MUL's destination.
                result_d = acc_q;
                waddr_d  = waddr_in;
                wen_d    = wen_rule;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
            wen_q    <= wen_d;
        end
    end

    assign result_out = result_q;
    assign waddr_out  = waddr_q;
    assign wen_out    = wen_q;

endmodule
